input_conditioner: RTL and testbench

Multi-channel input conditioning stage that sits directly upstream of the primitive register stage. It cleans asynchronous, possibly bouncy external inputs before they reach that stage's D inputs: each channel is synchronised into `clk_i`, then debounced with a per-channel counter. It outputs a stable level per channel plus single-cycle rise and fall strobes. All channels are independent and share one clock and reset.

---
 rtl/input_conditioner.sv | 70 +++++++
 tb/tb_input_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel synchroniser followed by a
// counter-based debouncer producing a stable level plus rise/fall strobes.
module input_conditioner #(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any return of s to the accepted level aborts the pending change and
    // discards the partial count; acceptance also clears it, so no overflow.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din_i[gi]};
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
        cnt_q  <= '0;
        dout_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dout_o[gi] = dout_q;
    assign rise_o[gi] = rise_q;
    assign fall_o[gi] = fall_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expectations are queued with the
// edge number they are due at, then compared on the following falling edge.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din, din1;
  logic [2:0] dout, rise, fall;
  logic [2:0] dout1, rise1, fall1;

  always #5 clk = ~clk;

  input_conditioner #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din),
    .dout_o(dout), .rise_o(rise), .fall_o(fall)
  );

  input_conditioner #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .din_i(din1),
    .dout_o(dout1), .rise_o(rise1), .fall_o(fall1)
  );

  typedef struct {
    int         cyc;
    bit         sel;
    string      tag;
    logic [2:0] d;
    logic [2:0] r;
    logic [2:0] f;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   num_checks = 0;
  int   num_pass = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs === exp) num_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc_cnt);
  endtask

  task automatic push_exp(input int cyc, input bit sel, input string tag,
                          input logic [2:0] d, input logic [2:0] r, input logic [2:0] f);
    exp_t x;
    x.cyc = cyc; x.sel = sel; x.tag = tag; x.d = d; x.r = r; x.f = f;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drained", sb.size(), 0);
  endtask

  // Falling-edge sampler: pops every expectation due at the current edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      check_eq({e.tag, "_edge"}, cyc_cnt, e.cyc);
      check_eq({e.tag, "_dout"}, e.sel ? dout1 : dout, e.d);
      check_eq({e.tag, "_rise"}, e.sel ? rise1 : rise, e.r);
      check_eq({e.tag, "_fall"}, e.sel ? fall1 : fall, e.f);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1; din = '0; din1 = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_dout", dout, 3'b000);
    check_eq("rst_rise", rise, 3'b000);
    check_eq("rst_fall", fall, 3'b000);
    check_eq("rst_dout1", dout1, 3'b000);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean rise on channel 0
    c = cyc_cnt; din = 3'b001;
    push_exp(c + 5, 0, "s1_pre", 3'b000, 3'b000, 3'b000);
    push_exp(c + 6, 0, "s1_rise", 3'b001, 3'b001, 3'b000);
    push_exp(c + 7, 0, "s1_hold", 3'b001, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);

    // 3-cycle glitch on channel 1 must be rejected
    c = cyc_cnt; din = 3'b011;
    for (int i = 1; i <= 20; i++) push_exp(c + i, 0, "s2_glitch", 3'b001, 3'b000, 3'b000);
    repeat (3) @(negedge clk);
    din = 3'b001;
    drain();
    repeat (2) @(negedge clk);

    // Bounce on channel 2, then settle high
    c = cyc_cnt;
    for (int i = 1; i <= 11; i++) push_exp(c + i, 0, "s3_bounce", 3'b001, 3'b000, 3'b000);
    push_exp(c + 12, 0, "s3_rise", 3'b101, 3'b100, 3'b000);
    push_exp(c + 13, 0, "s3_hold", 3'b101, 3'b000, 3'b000);
    for (int k = 0; k < 7; k++) begin
      din = (k % 2 == 0) ? 3'b101 : 3'b001;
      @(negedge clk);
    end
    drain();
    repeat (2) @(negedge clk);

    // Drop channel 0 to reach 3'b100, then swap channels simultaneously
    c = cyc_cnt; din = 3'b100;
    push_exp(c + 6, 0, "s4_fall0", 3'b100, 3'b000, 3'b001);
    push_exp(c + 7, 0, "s4_hold0", 3'b100, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);
    c = cyc_cnt; din = 3'b001;
    push_exp(c + 5, 0, "s4_pre", 3'b100, 3'b000, 3'b000);
    push_exp(c + 6, 0, "s4_simul", 3'b001, 3'b001, 3'b100);
    push_exp(c + 7, 0, "s4_hold", 3'b001, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);

    // Synchronise-only build: rise at edge 3, then a 1-cycle glitch
    c = cyc_cnt; din1 = 3'b001;
    push_exp(c + 2, 1, "s6_pre", 3'b000, 3'b000, 3'b000);
    push_exp(c + 3, 1, "s6_rise", 3'b001, 3'b001, 3'b000);
    push_exp(c + 4, 1, "s6_hold", 3'b001, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);
    c = cyc_cnt; din1 = 3'b011;
    push_exp(c + 2, 1, "s6_gpre", 3'b001, 3'b000, 3'b000);
    push_exp(c + 3, 1, "s6_grise", 3'b011, 3'b010, 3'b000);
    push_exp(c + 4, 1, "s6_gfall", 3'b001, 3'b000, 3'b010);
    push_exp(c + 5, 1, "s6_gpost", 3'b001, 3'b000, 3'b000);
    @(negedge clk); din1 = 3'b001;
    drain();
    repeat (2) @(negedge clk);

    // All high, then channel 0 pending when reset hits
    c = cyc_cnt; din = 3'b111;
    push_exp(c + 6, 0, "s5_rise", 3'b111, 3'b110, 3'b000);
    push_exp(c + 7, 0, "s5_hold", 3'b111, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);
    din = 3'b110;
    repeat (3) @(negedge clk);
    check_eq("s5_pending_dout", dout, 3'b111);
    #2 rst = 1'b1;
    #1;
    check_eq("s5_async_dout", dout, 3'b000);
    check_eq("s5_async_rise", rise, 3'b000);
    check_eq("s5_async_fall", fall, 3'b000);
    check_eq("s5_async_dout1", dout1, 3'b000);
    din = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = cyc_cnt;
    push_exp(c + 5, 0, "s5_rel_pre", 3'b000, 3'b000, 3'b000);
    push_exp(c + 6, 0, "s5_rel_rise", 3'b111, 3'b111, 3'b000);
    push_exp(c + 7, 0, "s5_rel_hold", 3'b111, 3'b000, 3'b000);
    drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
